// File: rtl/clic_claim_pkg.sv
// clic_claim_pkg -- shared definitions for the CLIC claim engine.
// Holds the scan FSM state encoding, the CLIC interrupt register map
// (per-source word offset and byte lanes) and the per-source address helper.
package clic_claim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_EVAL    = 3'd3,
    ST_PRESENT = 3'd4,
    ST_CLEAR   = 3'd5,
    ST_CWAIT   = 3'd6
  } state_t;

  // Per-source interrupt words start 4 KiB above the CLIC base.
  localparam logic [31:0] INT_OFFSET = 32'd4096;

  // Byte lanes of a source word: ip, ie, attr, ctl.
  localparam int IP_LSB   = 0;
  localparam int IE_LSB   = 8;
  localparam int ATTR_LSB = 16;
  localparam int CTL_LSB  = 24;

  // attr bit that marks an edge-triggered source (pending must be cleared).
  localparam int ATTR_EDGE_BIT = 1;

  // Byte address of the register word of source idx.
  function automatic logic [31:0] src_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + INT_OFFSET + (idx << 2);
  endfunction

endpackage

// File: rtl/clic_claim.sv
// clic_claim -- scans every CLIC source word over a simple request/ready bus
// when the CLIC signals a pending interrupt, picks the pending+enabled source
// with the highest ctl (lowest index on ties), presents it to the core and,
// for edge-triggered winners, clears its ip byte after the core acknowledges.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clic_meip           interrupt pending indication from the CLIC
//   clic_valid/instr/addr/wdata/wstrb   bus request (wstrb 0 = read)
//   clic_rdata/ready    bus response
//   irq_valid/id/level  claimed interrupt towards the core, irq_ack accepts it
//   bus_error           sticky flag, set when any transaction times out
module clic_claim
  import clic_claim_pkg::*;
#(
  parameter int          clic_sources = 7,
  parameter logic [31:0] clic_base    = 32'h0,
  parameter int          clic_timeout = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clic_meip,
  output logic                    clic_valid,
  output logic                    clic_instr,
  output logic [31:0]             clic_addr,
  output logic [31:0]             clic_wdata,
  output logic [3:0]              clic_wstrb,
  input  logic [31:0]             clic_rdata,
  input  logic                    clic_ready,
  output logic                    irq_valid,
  output logic [clic_sources-1:0] irq_id,
  output logic [7:0]              irq_level,
  input  logic                    irq_ack,
  output logic                    bus_error
);

  localparam logic [clic_sources-1:0] IDX_LAST = {clic_sources{1'b1}};
  localparam logic [clic_sources-1:0] IDX_ONE  = {{(clic_sources-1){1'b0}}, 1'b1};
  localparam logic [clic_timeout-1:0] TMO_MAX  = {clic_timeout{1'b1}};
  localparam logic [clic_timeout-1:0] TMO_ONE  = {{(clic_timeout-1){1'b0}}, 1'b1};

  state_t                  state_r;
  logic [clic_sources-1:0] index_r;
  logic [clic_sources-1:0] best_id_r;
  logic [7:0]              best_level_r;
  logic                    best_edge_r;
  logic                    found_r;
  logic [31:0]             rdata_r;
  logic [clic_timeout-1:0] tmo_r;

  logic                    cand_s;
  logic                    take_s;
  logic                    found_next_s;
  logic [clic_sources-1:0] win_id_s;
  logic [7:0]              win_level_s;
  logic                    win_edge_s;
  logic                    last_s;
  logic                    tmo_done_s;
  logic [31:0]             next_addr_s;
  logic [31:0]             win_addr_s;
  logic                    unused_s;

  // Requests are never instruction fetches.
  assign clic_instr = 1'b0;

  // Lanes of the latched word that the selection does not look at.
  assign unused_s = ^{rdata_r[IE_LSB-1:IP_LSB+1], rdata_r[ATTR_LSB-1:IE_LSB+1],
                      rdata_r[CTL_LSB-1:ATTR_LSB+ATTR_EDGE_BIT+1], rdata_r[ATTR_LSB]};

  // Selection of the running best candidate and next-address arithmetic.
  always_comb begin
    cand_s       = rdata_r[IP_LSB] & rdata_r[IE_LSB];
    // Strict compare keeps the earlier (lower) index on equal ctl.
    take_s       = cand_s & (~found_r | (rdata_r[CTL_LSB +: 8] > best_level_r));
    found_next_s = found_r | take_s;
    if (take_s) begin
      win_id_s    = index_r;
      win_level_s = rdata_r[CTL_LSB +: 8];
      win_edge_s  = rdata_r[ATTR_LSB + ATTR_EDGE_BIT];
    end else begin
      win_id_s    = best_id_r;
      win_level_s = best_level_r;
      win_edge_s  = best_edge_r;
    end
    last_s      = (index_r == IDX_LAST);
    tmo_done_s  = (tmo_r == TMO_MAX);
    next_addr_s = src_addr(clic_base, 32'(index_r + IDX_ONE));
    win_addr_s  = src_addr(clic_base, 32'(best_id_r));
  end

  // Scan/claim/clear state machine with registered bus and core outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      index_r      <= '0;
      best_id_r    <= '0;
      best_level_r <= 8'h00;
      best_edge_r  <= 1'b0;
      found_r      <= 1'b0;
      rdata_r      <= 32'h0;
      tmo_r        <= '0;
      clic_valid   <= 1'b0;
      clic_addr    <= 32'h0;
      clic_wdata   <= 32'h0;
      clic_wstrb   <= 4'b0000;
      irq_valid    <= 1'b0;
      irq_id       <= '0;
      irq_level    <= 8'h00;
      bus_error    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          clic_valid <= 1'b0;
          if (clic_meip) begin
            state_r      <= ST_REQ;
            index_r      <= '0;
            best_id_r    <= '0;
            best_level_r <= 8'h00;
            best_edge_r  <= 1'b0;
            found_r      <= 1'b0;
            clic_valid   <= 1'b1;
            clic_addr    <= src_addr(clic_base, 32'd0);
            clic_wstrb   <= 4'b0000;
            clic_wdata   <= 32'h0;
          end
        end
        ST_REQ: begin
          clic_valid <= 1'b0;
          tmo_r      <= '0;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (clic_ready) begin
            rdata_r <= clic_rdata;
            state_r <= ST_EVAL;
          end else if (tmo_done_s) begin
            // A lost response reads as an idle source.
            rdata_r   <= 32'h0;
            bus_error <= 1'b1;
            state_r   <= ST_EVAL;
          end else begin
            tmo_r <= tmo_r + TMO_ONE;
          end
        end
        ST_EVAL: begin
          best_id_r    <= win_id_s;
          best_level_r <= win_level_s;
          best_edge_r  <= win_edge_s;
          found_r      <= found_next_s;
          if (last_s) begin
            if (found_next_s) begin
              irq_valid <= 1'b1;
              irq_id    <= win_id_s;
              irq_level <= win_level_s;
              state_r   <= ST_PRESENT;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            index_r    <= index_r + IDX_ONE;
            clic_valid <= 1'b1;
            clic_addr  <= next_addr_s;
            clic_wstrb <= 4'b0000;
            state_r    <= ST_REQ;
          end
        end
        ST_PRESENT: begin
          if (irq_ack) begin
            irq_valid <= 1'b0;
            if (best_edge_r) begin
              // Edge-triggered: write zero into the ip byte only.
              clic_valid <= 1'b1;
              clic_addr  <= win_addr_s;
              clic_wstrb <= 4'b0001;
              clic_wdata <= 32'h0;
              state_r    <= ST_CLEAR;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_CLEAR: begin
          clic_valid <= 1'b0;
          clic_wstrb <= 4'b0000;
          tmo_r      <= '0;
          state_r    <= ST_CWAIT;
        end
        ST_CWAIT: begin
          if (clic_ready) begin
            state_r <= ST_IDLE;
          end else if (tmo_done_s) begin
            bus_error <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            tmo_r <= tmo_r + TMO_ONE;
          end
        end
        default: begin
          clic_valid <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clic_claim.sv
// tb_clic_claim -- randomized scoreboard bench for clic_claim.
// A behavioural CLIC responder answers reads from a source memory with random
// latency; a reference model picks the expected winner from that memory; a
// monitor pops expected claims when irq_valid rises, and the responder pops
// expected clear writes when a write is seen.
module tb_clic_claim;

  localparam int          NSRC = 128;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        clic_meip;
  logic        clic_valid;
  logic        clic_instr;
  logic [31:0] clic_addr;
  logic [31:0] clic_wdata;
  logic [3:0]  clic_wstrb;
  logic [31:0] clic_rdata;
  logic        clic_ready;
  logic        irq_valid;
  logic [6:0]  irq_id;
  logic [7:0]  irq_level;
  logic        irq_ack;
  logic        bus_error;

  clic_claim #(.clic_sources(7), .clic_base(BASE), .clic_timeout(4)) dut (
    .clk(clk), .rst(rst), .clic_meip(clic_meip),
    .clic_valid(clic_valid), .clic_instr(clic_instr), .clic_addr(clic_addr),
    .clic_wdata(clic_wdata), .clic_wstrb(clic_wstrb), .clic_rdata(clic_rdata),
    .clic_ready(clic_ready), .irq_valid(irq_valid), .irq_id(irq_id),
    .irq_level(irq_level), .irq_ack(irq_ack), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int level;} claim_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [31:0] mem    [NSRC];
  bit          silent [NSRC];
  int          lat    [NSRC];
  claim_t      exp_claim [$];
  logic [31:0] exp_write [$];
  logic [31:0] req_addrs [$];
  int          req_cycles[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] src(input logic ip, input logic ie, input logic [7:0] attr, input logic [7:0] ctl);
    return {ctl, attr, 7'd0, ie, 7'd0, ip};
  endfunction

  function automatic bit is_cand(input int i);
    return !silent[i] && mem[i][0] && mem[i][8];
  endfunction

  // Reference: highest ctl among answering pending+enabled sources, lowest index among equals.
  task automatic model(output bit found, output int id, output int lvl, output bit edg);
    int best;
    best = -1;
    for (int i = 0; i < NSRC; i++)
      if (is_cand(i) && int'(mem[i][31:24]) > best) best = int'(mem[i][31:24]);
    found = (best >= 0);
    id = 0; lvl = 0; edg = 1'b0;
    if (found) begin
      for (int i = NSRC - 1; i >= 0; i--)
        if (is_cand(i) && int'(mem[i][31:24]) == best) id = i;
      lvl = best;
      edg = mem[id][17];
    end
  endtask

  // Responder: answers reads after 1+lat cycles, checks and answers clear writes.
  initial begin
    logic [31:0] a;
    logic [31:0] ew;
    int          idx;
    clic_ready = 1'b0;
    clic_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && clic_valid) begin
        a = clic_addr;
        if (clic_wstrb == 4'b0000) begin
          req_addrs.push_back(a);
          req_cycles.push_back(cyc);
          idx = int'((a - BASE - 32'd4096) >> 2);
          if (idx >= 0 && idx < NSRC && !silent[idx]) begin
            repeat (lat[idx] + 1) @(negedge clk);
            clic_rdata = mem[idx];
            clic_ready = 1'b1;
            @(negedge clk);
            clic_ready = 1'b0;
            clic_rdata = 32'h0;
          end
        end else begin
          check("write_expected", 32'(exp_write.size() > 0), 32'd1);
          if (exp_write.size() > 0) begin
            ew = exp_write.pop_front();
            check("clear_addr", a, ew);
            check("clear_wstrb", 32'(clic_wstrb), 32'h1);
            check("clear_wdata", clic_wdata, 32'h0);
          end
          @(negedge clk);
          clic_ready = 1'b1;
          @(negedge clk);
          clic_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: compares each new claim against the scoreboard, then checks it stays stable.
  initial begin
    bit     prev;
    claim_t c;
    prev = 1'b0;
    c.id = 0; c.level = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (irq_valid && !prev) begin
          check("claim_expected", 32'(exp_claim.size() > 0), 32'd1);
          if (exp_claim.size() > 0) begin
            c = exp_claim.pop_front();
            check("irq_id", 32'(irq_id), 32'(c.id));
            check("irq_level", 32'(irq_level), 32'(c.level));
          end
        end else if (irq_valid && prev) begin
          check("irq_hold", {17'd0, irq_id, irq_level}, {17'd0, 7'(c.id), 8'(c.level)});
        end
        prev = irq_valid;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < NSRC; i++) begin
      mem[i] = 32'h0; silent[i] = 1'b0; lat[i] = 0;
    end
  endtask

  // One complete scan: push expectations, pulse meip, wait for / ack the claim.
  task automatic run_scan(input string tag, input bit zero_lat);
    bit     found, edg;
    int     id, lvl, bound, n;
    bit     ok;
    claim_t c;
    model(found, id, lvl, edg);
    if (found) begin
      c.id = id; c.level = lvl;
      exp_claim.push_back(c);
      if (edg) exp_write.push_back(BASE + 32'd4096 + 32'(4 * id));
    end
    bound = 60;
    for (int i = 0; i < NSRC; i++) bound += 3 + lat[i] + (silent[i] ? 17 : 0);
    req_addrs.delete();
    req_cycles.delete();
    @(negedge clk) clic_meip = 1'b1;
    repeat (2) @(negedge clk);
    clic_meip = 1'b0;
    n = 0;
    while (n < bound && !(found && irq_valid)) begin
      // Stray acks outside PRESENT must be ignored.
      irq_ack = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      n++;
    end
    irq_ack = 1'b0;
    if (found) begin
      check({tag, "_claim_seen"}, 32'(irq_valid), 32'd1);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
      check({tag, "_irq_drop"}, 32'(irq_valid), 32'd0);
    end else begin
      check({tag, "_no_claim"}, 32'(irq_valid), 32'd0);
    end
    repeat (30) @(negedge clk);
    check({tag, "_claims_left"}, 32'(exp_claim.size()), 32'd0);
    check({tag, "_writes_left"}, 32'(exp_write.size()), 32'd0);
    check({tag, "_reads"}, 32'(req_addrs.size()), 32'(NSRC));
    ok = 1'b1;
    for (int i = 0; i < req_addrs.size() && i < NSRC; i++)
      if (req_addrs[i] != BASE + 32'd4096 + 32'(4 * i)) ok = 1'b0;
    check({tag, "_addr_seq"}, 32'(ok), 32'd1);
    if (zero_lat && req_cycles.size() == NSRC)
      check({tag, "_scan_cycles"}, 32'(req_cycles[NSRC-1] - req_cycles[0]), 32'(3 * (NSRC - 1)));
  endtask

  initial begin
    int n;
    rst = 1'b1; clic_meip = 1'b0; irq_ack = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(clic_valid), 32'd0);
    check("rst_irq_valid", 32'(irq_valid), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_instr", 32'(clic_instr), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Higher ctl wins; non-candidates with large ctl are ignored.
    clear_mem();
    mem[3] = src(1'b1, 1'b1, 8'h00, 8'h40);
    mem[9] = src(1'b1, 1'b1, 8'h00, 8'h80);
    mem[10] = src(1'b1, 1'b0, 8'h02, 8'hFF);
    mem[11] = src(1'b0, 1'b1, 8'h02, 8'hFF);
    run_scan("prio", 1'b1);

    // Equal ctl keeps the lowest index.
    clear_mem();
    mem[5] = src(1'b1, 1'b1, 8'h00, 8'h30);
    mem[2] = src(1'b1, 1'b1, 8'h00, 8'h30);
    run_scan("tie", 1'b1);

    // Edge-triggered winner is cleared; level-triggered winner is not.
    clear_mem();
    mem[6] = src(1'b1, 1'b1, 8'h02, 8'h55);
    mem[127] = src(1'b1, 1'b1, 8'h00, 8'h20);
    run_scan("edge", 1'b1);
    mem[6] = src(1'b1, 1'b1, 8'h00, 8'h55);
    run_scan("level", 1'b1);
    clear_mem();
    mem[127] = src(1'b1, 1'b1, 8'h02, 8'h01);
    run_scan("last_src", 1'b1);

    // Nothing enabled: full scan, no claim.
    clear_mem();
    for (int i = 0; i < NSRC; i += 3) mem[i] = src(1'b1, 1'b0, 8'h02, 8'h99);
    run_scan("none", 1'b1);

    // Random source tables and responder latencies.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NSRC; i++) begin
        mem[i] = src($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                     8'($urandom), 8'($urandom_range(0, 7) * 32));
        silent[i] = 1'b0;
        lat[i] = $urandom_range(0, 3);
      end
      run_scan("rand", 1'b0);
    end

    // Unanswered source times out, flags bus_error and is skipped.
    check("bus_error_pre", 32'(bus_error), 32'd0);
    clear_mem();
    mem[4] = src(1'b1, 1'b1, 8'h02, 8'hFF);
    silent[4] = 1'b1;
    mem[7] = src(1'b1, 1'b1, 8'h00, 8'h10);
    run_scan("timeout", 1'b0);
    check("bus_error_post", 32'(bus_error), 32'd1);

    // Reset while waiting on source 20 abandons the scan.
    clear_mem();
    silent[20] = 1'b1;
    req_addrs.delete();
    @(negedge clk) clic_meip = 1'b1;
    repeat (2) @(negedge clk);
    clic_meip = 1'b0;
    n = 0;
    while (n < 1000 && req_addrs.size() < 21) begin
      @(negedge clk);
      n++;
    end
    check("reach_src20", 32'(req_addrs.size() >= 21), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_valid", 32'(clic_valid), 32'd0);
    check("mrst_wstrb", 32'(clic_wstrb), 32'd0);
    check("mrst_wdata", clic_wdata, 32'h0);
    check("mrst_addr", clic_addr, 32'h0);
    check("mrst_irq_valid", 32'(irq_valid), 32'd0);
    check("mrst_irq_id", 32'(irq_id), 32'd0);
    check("mrst_irq_level", 32'(irq_level), 32'd0);
    check("mrst_bus_error", 32'(bus_error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    silent[20] = 1'b0;
    mem[20] = src(1'b1, 1'b1, 8'h02, 8'h70);
    repeat (2) @(negedge clk);
    run_scan("after_rst", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
